// File: rtl/memory_sdpram.sv
// memory_sdpram: simple dual-port RAM, one write port (A) and one read port (B)
// on a single common clock. Storage primitive for synchronous FIFOs and buffers.
//
// Ports:
//   clk     common clock for both ports
//   rst_n   async active-low reset; clears the read output registers only
//   ena     write port enable
//   wea     per-lane write enables, one bit per BYTE_WRITE_WIDTH slice of dina
//   addra   write address (writes at or beyond DEPTH are dropped)
//   dina    write data
//   enb     read enable for the first read stage
//   regceb  clock enable for the second output register (READ_LATENCY=2 only)
//   addrb   read address (reads at or beyond DEPTH return zero)
//   doutb   read data; combinational (latency 0) or registered (latency 1/2)
module memory_sdpram #(
    parameter int                    ADDR_WIDTH       = 6,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    BYTE_WRITE_WIDTH = 32,
    parameter int                    MEMORY_SIZE      = 2048,
    parameter int                    READ_LATENCY     = 1,
    parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = '0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     ena,
    input  logic [DATA_WIDTH/BYTE_WRITE_WIDTH-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]                    addra,
    input  logic [DATA_WIDTH-1:0]                    dina,
    input  logic                                     enb,
    input  logic                                     regceb,
    input  logic [ADDR_WIDTH-1:0]                    addrb,
    output logic [DATA_WIDTH-1:0]                    doutb
);

    localparam int DEPTH     = MEMORY_SIZE / DATA_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WRITE_WIDTH;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the range compare holds even when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_err_depth
        $error("memory_sdpram: DEPTH exceeds 2**ADDR_WIDTH");
    end
    if ((DATA_WIDTH % BYTE_WRITE_WIDTH) != 0) begin : g_err_lane
        $error("memory_sdpram: DATA_WIDTH is not a multiple of BYTE_WRITE_WIDTH");
    end
    if ((READ_LATENCY < 0) || (READ_LATENCY > 2)) begin : g_err_lat
        $error("memory_sdpram: READ_LATENCY must be 0, 1 or 2");
    end

    // Contents come up as zero (bitstream/power-up init) and are never reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  wr_ok;
    logic                  rd_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        wr_ok   = ena && ({1'b0, addra} < DEPTH_A);
        rd_ok   = ({1'b0, addrb} < DEPTH_A);
        wr_idx  = addra[IDX_W-1:0];
        rd_idx  = addrb[IDX_W-1:0];
        rd_word = rd_ok ? mem_q[rd_idx] : '0;
    end

    // Per-lane write; rd_word samples the pre-edge contents, so a same-address
    // read on the write edge is naturally read-first.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_ok && wea[i]) begin
                mem_q[wr_idx][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
                    dina[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_lat0
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = &{1'b0, enb, regceb, rst_n};
        assign doutb = rd_word;
    end else begin : g_lat12
        logic [DATA_WIDTH-1:0] r1_d;
        logic [DATA_WIDTH-1:0] r1_q;

        always_comb begin
            r1_d = r1_q;
            if (enb) begin
                r1_d = rd_word;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r1_q <= READ_RESET_VALUE;
            end else begin
                r1_q <= r1_d;
            end
        end

        if (READ_LATENCY == 1) begin : g_lat1
            logic unused_regceb;
            assign unused_regceb = &{1'b0, regceb};
            assign doutb = r1_q;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] r2_d;
            logic [DATA_WIDTH-1:0] r2_q;

            always_comb begin
                r2_d = r2_q;
                if (regceb) begin
                    r2_d = r1_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r2_q <= READ_RESET_VALUE;
                end else begin
                    r2_q <= r2_d;
                end
            end

            assign doutb = r2_q;
        end
    end

endmodule

// File: tb/tb_memory_sdpram.sv
// Bench for memory_sdpram. Four instances share clk and rst_n:
//   0: latency 0, 32-bit lanes
//   1: latency 1, reset value A5A5A5A5
//   2: latency 2, reset value CAFE0000
//   3: latency 1, 8-bit lanes, DEPTH 40 (for out-of-range addresses)
// Stimulus pushes {instance, due cycle, value} onto a scoreboard; the monitor
// samples on the falling edge and compares every entry that is due.
module tb_memory_sdpram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        ena    [4];
    logic [3:0]  wea    [4];
    logic [5:0]  addra  [4];
    logic [5:0]  addrb  [4];
    logic [31:0] dina   [4];
    logic        enb    [4];
    logic        regceb [4];
    logic [31:0] dout   [4];

    memory_sdpram #(.READ_LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .ena(ena[0]), .wea(wea[0][0:0]), .addra(addra[0]),
        .dina(dina[0]), .enb(enb[0]), .regceb(regceb[0]), .addrb(addrb[0]), .doutb(dout[0]));

    memory_sdpram #(.READ_LATENCY(1), .READ_RESET_VALUE(32'hA5A5_A5A5)) u_l1 (
        .clk(clk), .rst_n(rst_n), .ena(ena[1]), .wea(wea[1][0:0]), .addra(addra[1]),
        .dina(dina[1]), .enb(enb[1]), .regceb(regceb[1]), .addrb(addrb[1]), .doutb(dout[1]));

    memory_sdpram #(.READ_LATENCY(2), .READ_RESET_VALUE(32'hCAFE_0000)) u_l2 (
        .clk(clk), .rst_n(rst_n), .ena(ena[2]), .wea(wea[2][0:0]), .addra(addra[2]),
        .dina(dina[2]), .enb(enb[2]), .regceb(regceb[2]), .addrb(addrb[2]), .doutb(dout[2]));

    memory_sdpram #(.READ_LATENCY(1), .BYTE_WRITE_WIDTH(8), .MEMORY_SIZE(1280)) u_bw (
        .clk(clk), .rst_n(rst_n), .ena(ena[3]), .wea(wea[3]), .addra(addra[3]),
        .dina(dina[3]), .enb(enb[3]), .regceb(regceb[3]), .addrb(addrb[3]), .doutb(dout[3]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        int          at;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expect dout[dut] == v at the falling edge 'dly' rising edges from now.
    function automatic void expect_at(input int dut, input int dly,
                                      input logic [31:0] v, input string name);
        exp_t e;
        e.dut  = dut;
        e.at   = cyc + dly;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].name, dout[sb[i].dut], sb[i].val);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: not sampled, due cycle %0d now %0d", sb[i].name, sb[i].at, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            ena[k] = 1'b0; wea[k] = '0; addra[k] = '0; addrb[k] = '0;
            dina[k] = '0; enb[k] = 1'b0; regceb[k] = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        tick();

        // Reset holds outputs; a write during reset still lands in memory.
        check("rst_hold_l1", dout[1], 32'hA5A5_A5A5);
        check("rst_hold_l2", dout[2], 32'hCAFE_0000);
        ena[1] = 1'b1; wea[1] = 4'h1; addra[1] = 6'd10; dina[1] = 32'h0BAD_F00D;
        tick();
        ena[1] = 1'b0;
        check("rst_hold_l1_after_wr", dout[1], 32'hA5A5_A5A5);

        rst_n = 1'b1;
        enb[1] = 1'b1; addrb[1] = 6'd3;
        expect_at(1, 0, 32'hA5A5_A5A5, "l1_reset_until_read");
        expect_at(1, 1, 32'h0000_0000, "l1_first_read_unwritten");
        tick();
        enb[1] = 1'b0;

        // Latency 1 write/read and hold with enb=0.
        ena[1] = 1'b1; addra[1] = 6'd5; dina[1] = 32'h1122_3344;
        tick();
        ena[1] = 1'b0;
        enb[1] = 1'b1; addrb[1] = 6'd5;
        expect_at(1, 1, 32'h1122_3344, "l1_read_5");
        tick();
        enb[1] = 1'b0; addrb[1] = 6'd6;
        expect_at(1, 1, 32'h1122_3344, "l1_hold_enb0");
        expect_at(1, 2, 32'h1122_3344, "l1_hold_enb0_2");
        tick();
        tick();
        enb[1] = 1'b1; addrb[1] = 6'd10;
        expect_at(1, 1, 32'h0BAD_F00D, "l1_write_during_reset");
        tick();
        enb[1] = 1'b0;

        // Read-first collision.
        ena[1] = 1'b1; addra[1] = 6'd7; dina[1] = 32'hAAAA_0000;
        tick();
        dina[1] = 32'h5555_FFFF;
        enb[1] = 1'b1; addrb[1] = 6'd7;
        expect_at(1, 1, 32'hAAAA_0000, "collision_read_first");
        tick();
        ena[1] = 1'b0;
        expect_at(1, 1, 32'h5555_FFFF, "collision_next_read");
        tick();
        enb[1] = 1'b0;
        tick();

        // Latency 0: combinational read, immune to enb and rst_n.
        addrb[0] = 6'd9;
        ena[0] = 1'b1; wea[0] = 4'h1; addra[0] = 6'd9; dina[0] = 32'hDEAD_BEEF;
        expect_at(0, 0, 32'h0000_0000, "l0_before_edge");
        expect_at(0, 1, 32'hDEAD_BEEF, "l0_after_edge");
        tick();
        ena[0] = 1'b0;
        rst_n = 1'b0;
        #1 check("l0_rst_low_imm", dout[0], 32'hDEAD_BEEF);
        expect_at(0, 0, 32'hDEAD_BEEF, "l0_rst_low");
        tick();
        rst_n = 1'b1;
        expect_at(0, 0, 32'hDEAD_BEEF, "l0_rst_released");
        tick();

        // Byte lanes.
        ena[3] = 1'b1; wea[3] = 4'b0101; addra[3] = 6'd2; dina[3] = 32'hFFFF_FFFF;
        tick();
        ena[3] = 1'b0; wea[3] = 4'b1111; dina[3] = 32'h1234_5678;
        enb[3] = 1'b1; addrb[3] = 6'd2;
        expect_at(3, 1, 32'h00FF_00FF, "lane_0101");
        tick();
        expect_at(3, 1, 32'h00FF_00FF, "lane_ena0_blocked");
        tick();
        enb[3] = 1'b0;
        ena[3] = 1'b1; wea[3] = 4'b1010; dina[3] = 32'hAB00_CD00;
        tick();
        ena[3] = 1'b0;
        enb[3] = 1'b1;
        expect_at(3, 1, 32'hABFF_CDFF, "lane_1010");
        tick();
        enb[3] = 1'b0;
        ena[3] = 1'b1; wea[3] = 4'b1111; addra[3] = 6'd45; dina[3] = 32'hFFFF_FFFF;
        tick();
        ena[3] = 1'b0;
        enb[3] = 1'b1; addrb[3] = 6'd45;
        expect_at(3, 1, 32'h0000_0000, "oob_read");
        tick();
        addrb[3] = 6'd13;
        expect_at(3, 1, 32'h0000_0000, "oob_no_alias_13");
        tick();
        addrb[3] = 6'd5;
        expect_at(3, 1, 32'h0000_0000, "oob_no_alias_5");
        tick();
        enb[3] = 1'b0;

        // Latency 2 and regceb.
        ena[2] = 1'b1; wea[2] = 4'h1; addra[2] = 6'd5; dina[2] = 32'h1122_3344;
        tick();
        addra[2] = 6'd6; dina[2] = 32'h7777_8888;
        tick();
        ena[2] = 1'b0;
        enb[2] = 1'b1; regceb[2] = 1'b1; addrb[2] = 6'd5;
        expect_at(2, 0, 32'hCAFE_0000, "l2_before");
        expect_at(2, 1, 32'hCAFE_0000, "l2_one_edge");
        expect_at(2, 2, 32'h1122_3344, "l2_two_edges");
        tick();
        enb[2] = 1'b0;
        tick();
        regceb[2] = 1'b0; enb[2] = 1'b1; addrb[2] = 6'd6;
        expect_at(2, 1, 32'h1122_3344, "l2_regceb0_hold");
        expect_at(2, 2, 32'h1122_3344, "l2_regceb0_hold_2");
        tick();
        enb[2] = 1'b0;
        tick();
        regceb[2] = 1'b1;
        expect_at(2, 1, 32'h7777_8888, "l2_regceb1_release");
        tick();
        enb[2] = 1'b1; addrb[2] = 6'd5;
        expect_at(2, 2, 32'h1122_3344, "l2_pre_reset");
        tick();
        tick();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("l2_async_reset", dout[2], 32'hCAFE_0000);
        check("l1_async_reset", dout[1], 32'hA5A5_A5A5);
        tick();
        rst_n = 1'b1;
        enb[2] = 1'b0;
        expect_at(2, 1, 32'hCAFE_0000, "l2_after_release");
        tick();
        repeat (4) tick();

        while (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: never sampled, due cycle %0d", sb[0].name, sb[0].at);
            void'(sb.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_sdpram.md
Name: memory_sdpram

Overview:
Simple dual-port RAM with one write port (A) and one read port (B), both on a single common clock. It provides the storage primitive for synchronous FIFOs and similar buffers. Read latency is selectable: 0 gives a combinational/distributed-style read, and 1 or 2 give a registered/block-style read. Only the output registers are resettable; memory contents are never cleared by reset.

Parameters:
ADDR_WIDTH, 6, width of addra/addrb.
DATA_WIDTH, 32, word width of dina/doutb.
BYTE_WRITE_WIDTH, 32, write-enable granularity in bits; DATA_WIDTH must be an integer multiple of it (8 or DATA_WIDTH typical).
MEMORY_SIZE, 2048, total bits; DEPTH = MEMORY_SIZE/DATA_WIDTH words, and DEPTH must be ≤ 2^ADDR_WIDTH.
READ_LATENCY, 1, read latency in clk cycles: 0, 1 or 2.
READ_RESET_VALUE, 0, value loaded into doutb output registers on reset (DATA_WIDTH bits).

Ports:
clk  in  1  common clock for both ports
rst_n  in  1  asynchronous active-low reset; affects output registers only
ena  in  1  write port enable
wea  in  DATA_WIDTH/BYTE_WRITE_WIDTH  per-byte-lane write enables (1 bit when BYTE_WRITE_WIDTH=DATA_WIDTH)
addra  in  ADDR_WIDTH  write address
dina  in  DATA_WIDTH  write data
enb  in  1  read port enable (first read stage)
regceb  in  1  clock enable for the final output register (used only when READ_LATENCY=2)
addrb  in  ADDR_WIDTH  read address
doutb  out  DATA_WIDTH  read data

Behaviour:
- Storage: array of DEPTH words; every word is 0 at time zero. rst_n never alters contents.
- Write: on posedge clk, if ena=1, then for each lane i with wea[i]=1, mem[addra] lane i <= dina lane i. Lanes with wea[i]=0 are unchanged. ena=0 blocks all writes.
- Writes to addra ≥ DEPTH are ignored. Reads from addrb ≥ DEPTH return 0.
- READ_LATENCY=0:
  - doutb = mem[addrb] combinationally; enb, regceb and rst_n have no effect.
  - A write to the addressed word is visible on doutb immediately after the writing clk edge.
- READ_LATENCY=1:
  - Single register R1. On posedge clk, if enb=1, R1 <= mem[addrb]; otherwise R1 holds.
  - doutb = R1. regceb is ignored.
- READ_LATENCY=2:
  - R1 is updated as in the latency-1 case.
  - Second register R2: on posedge clk, if regceb=1, R2 <= R1; otherwise R2 holds.
  - doutb = R2.
- Collision (READ_LATENCY≥1), same address written and read on the same edge: read-first. The read captures the pre-write contents; the new data is returned by the next read.
- Reset: rst_n low immediately (asynchronously) forces R1 and R2 to READ_RESET_VALUE. doutb equals READ_RESET_VALUE while rst_n is low and until the first enabled read completes.
  - Reset release is synchronous-safe: the first edge after deassertion may perform normal reads/writes.
  - Writes occurring on an edge while rst_n is low still update memory.
- Parameter violations (DEPTH > 2^ADDR_WIDTH, DATA_WIDTH not a multiple of BYTE_WRITE_WIDTH, READ_LATENCY > 2) are elaboration errors.
- No ECC, sleep or power-management features.

Test Plan:
- Reset/init, READ_LATENCY=1, READ_RESET_VALUE=0xA5A5A5A5:
  - Hold rst_n=0 → doutb=0xA5A5A5A5.
  - Release, enb=1 with addrb=3 (never written) → doutb=0 one edge later.
- Write/read, latency 1:
  - Write 0x11223344 to addr 5 (ena=1, wea=1).
  - Next cycle, enb=1 with addrb=5 → doutb=0x11223344 after one edge.
  - enb=0 with addrb=6 → doutb holds 0x11223344.
- Read-first collision:
  - mem[7]=0xAAAA0000. On the same edge, write 0x5555FFFF to addr 7 and read addr 7 → doutb=0xAAAA0000.
  - Next read of addr 7 → 0x5555FFFF.
- Latency 0:
  - addrb=9; write 0xDEADBEEF to addr 9 → doutb=0xDEADBEEF right after that edge, with enb=0.
  - Toggling rst_n → no change on doutb.
- Byte lanes, BYTE_WRITE_WIDTH=8:
  - mem[2]=0x00000000; write dina=0xFFFFFFFF with wea=4'b0101 → read returns 0x00FF00FF.
  - ena=0 with wea=4'b1111 → contents unchanged.
- Latency 2 / regceb:
  - Read addr 5 (0x11223344) with regceb=1 → doutb updates two edges after the read request.
  - With regceb=0, doutb holds its old value even though R1 has updated.
  - Asserting rst_n=0 mid-stream → doutb=READ_RESET_VALUE immediately.
